// File: rtl/div_ctrl_if.sv
// Handshake and data bundle between the EX-stage pipeline and the divide sequencer.
interface div_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             ex_hold;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (output start, signed_op, a, b, flush, ex_hold,
                  input  stall, busy, done, quot, rem);
  modport slave  (input  start, signed_op, a, b, flush, ex_hold,
                  output stall, busy, done, quot, rem);
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring DIV/DIVU sequencer, one quotient bit per cycle.
// Optional DIV_ZERO_BYPASS_EN: a zero divisor skips the iterations and finishes next cycle.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      resetn,
  div_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] qreg, dvsr, quot_r, rem_r;
  logic             sign_q, sign_r;
  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH+1:0] sh, diff;
  logic             trial_ok;

  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign a_abs  = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs  = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Shifted remainder carries one extra bit so the trial subtract's borrow lands in the MSB.
  assign sh       = {prem, qreg[WIDTH-1]};
  assign diff     = sh - {2'b00, dvsr};
  assign trial_ok = !diff[WIDTH+1];

  always_ff @(posedge clk) begin
    if (resetn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (bus.start) begin
`ifdef DIV_ZERO_BYPASS_EN
          state_nxt = (bus.b == '0) ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
        CALC:    if (cnt == '0) state_nxt = FIXUP;
        FIXUP:   state_nxt = DONE;
        DONE:    if (!bus.ex_hold) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      cnt    <= '0;
      prem   <= '0;
      qreg   <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else if (accept) begin
      dvsr   <= b_abs;
      sign_q <= bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      sign_r <= bus.signed_op && bus.a[WIDTH-1];
      prem   <= '0;
      qreg   <= a_abs;
      cnt    <= CW'(WIDTH-1);
`ifdef DIV_ZERO_BYPASS_EN
      if (bus.b == '0) begin
        quot_r <= '1;
        rem_r  <= bus.a;
      end
`endif
    end else if (state == CALC) begin
      prem <= trial_ok ? diff[WIDTH:0] : sh[WIDTH:0];
      qreg <= {qreg[WIDTH-2:0], trial_ok};
      cnt  <= cnt - 1'b1;
    end else if (state == FIXUP && !bus.flush) begin
      // A flush landing on FIXUP must leave the previous results untouched.
      quot_r <= sign_q ? -qreg : qreg;
      rem_r  <= sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    end
  end

  assign bus.stall = bus.start && (state != DONE) && !bus.flush && !resetn;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.quot  = quot_r;
  assign bus.rem   = rem_r;
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized ops vs a 64-bit arithmetic model.
module tb_div_ctrl;
  localparam int W = 32;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_ctrl_if #(.WIDTH(W)) bus();
  div_ctrl #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of DIV/DIVU.
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1;
      r = a;
      if (s && !BYP && a[31]) q = 32'd1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.a         = a;
    bus.b         = b;
  endtask

  // Called at the negedge of the acceptance cycle with operands already driven.
  task automatic finish(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] eq, er;
    int lat, c;
    bit stall_ok;
    model(s, a, b, eq, er);
    lat = (BYP && b == 0) ? 1 : W + 2;
    #1 chk({tag, "_stall_c0"}, bus.stall, 1);
    c = 0;
    stall_ok = 1'b1;
    while (!bus.done && c < 200) begin
      @(negedge clk);
      c++;
      if (!bus.done && !bus.stall) stall_ok = 1'b0;
    end
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_stall_hi"}, stall_ok, 1);
    chk({tag, "_stall_done"}, bus.stall, 0);
    chk({tag, "_quot"}, bus.quot, eq);
    chk({tag, "_rem"}, bus.rem, er);
    bus.ex_hold = (hold > 0);
    if (hold == 0) bus.start = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_done"}, bus.done, 1);
      chk({tag, "_hold_quot"}, bus.quot, eq);
      chk({tag, "_hold_rem"}, bus.rem, er);
      chk({tag, "_hold_stall"}, bus.stall, 0);
      if (i == hold) begin
        bus.ex_hold = 1'b0;
        bus.start   = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_exit_busy"}, bus.busy, 0);
    chk({tag, "_exit_done"}, bus.done, 0);
  endtask

  initial begin
    bit s;
    logic [31:0] a, b;
    int mode;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.ex_hold = 1'b0;

    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quot", bus.quot, 0);
    chk("rst_rem", bus.rem, 0);
    bus.start = 1'b0;
    resetn = 1'b0;
    @(negedge clk);

    launch(0, 100, 7);                 finish(0, 100, 7, 0, "divu_100_7");
    launch(1, 32'hFFFF_FFF9, 2);       finish(1, 32'hFFFF_FFF9, 2, 0, "div_m7_2");
    launch(1, 32'h8000_0000, '1);      finish(1, 32'h8000_0000, '1, 0, "div_ovf");
    launch(0, 5, 0);                   finish(0, 5, 0, 0, "divu_5_0");
    launch(1, 32'hFFFF_FFFB, 0);       finish(1, 32'hFFFF_FFFB, 0, 0, "div_m5_0");
    launch(1, 12345, 32'hFFFF_FFF0);   finish(1, 12345, 32'hFFFF_FFF0, 3, "hold3");

    // start and flush together in IDLE must not be accepted
    bus.flush = 1'b1;
    launch(0, 50, 6);
    #1 chk("sf_stall", bus.stall, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("sf_busy", bus.busy, 0);
    finish(0, 50, 6, 0, "sf_next");

    // flush mid-CALC, then the held start is accepted with new operands
    launch(0, 1000, 3);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    bus.a = 9;
    bus.b = 3;
    #1;
    chk("fl_stall", bus.stall, 0);
    chk("fl_done", bus.done, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl_busy", bus.busy, 0);
    chk("fl_done_after", bus.done, 0);
    finish(0, 9, 3, 0, "fl_next");

    // reset mid-CALC clears everything
    launch(0, 77777, 13);
    repeat (20) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("mrst_quot", bus.quot, 0);
    chk("mrst_rem", bus.rem, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_stall", bus.stall, 0);
    resetn = 1'b0;
    launch(0, 8, 2);                   finish(0, 8, 2, 0, "mrst_next");

    for (int k = 0; k < 16; k++) begin
      s    = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'($urandom);
        default: b = '1;
      endcase
      launch(s, a, b);
      finish(s, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
